// File: rtl/stream_mux_n.sv
// N-channel packet stream multiplexer with registered output stage.
// Locks to one channel per packet; selection by sel or round-robin.
module stream_mux_n #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH-1:0]   in_last,
  output logic [N_CH-1:0]   in_ready,
  input  logic [SW-1:0]     sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [SW-1:0]     grant,
  output logic              locked
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] grant_nx;
  logic [SW-1:0] rr, rr_nx;
  logic [SW-1:0] pick;
  logic          found;
  logic          can_take;
  logic          xfer;
  int            c;

  assign locked   = (state == LOCKED);
  assign can_take = !out_valid || out_ready;
  assign xfer     = locked && can_take && in_valid[grant];

  always_comb begin
    in_ready = '0;
    if (locked && can_take)
      in_ready[grant] = 1'b1;
  end

  // Round-robin scans rr+1 .. rr+N_CH, wrapping without a power-of-two mask
  always_comb begin
    pick  = '0;
    found = 1'b0;
    c     = 0;
    if (MODE == 0) begin
      if (int'(sel) < N_CH && in_valid[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end else begin
      for (int i = 1; i <= N_CH; i++) begin
        c = int'(rr) + i;
        if (c >= N_CH)
          c = c - N_CH;
        if (!found && in_valid[c]) begin
          found = 1'b1;
          pick  = SW'(c);
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant_nx = grant;
    rr_nx    = rr;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_nx = LOCKED;
          grant_nx = pick;
          if (MODE != 0)
            rr_nx = pick;
        end
      end
      LOCKED: begin
        if (xfer && in_last[grant])
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr        <= SW'(N_CH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      rr    <= rr_nx;
      if (xfer) begin
        out_data  <= in_data[int'(grant)*W +: W];
        out_last  <= in_last[grant];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: ext-select, round-robin and
// a 3-channel build, driven with directed packets.
module tb_stream_mux_n;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0;
  logic [N-1:0] in_last = '0;
  logic [1:0]   sel = '0;
  logic         out_ready = 1'b0;

  logic [N-1:0] u0_ready, u1_ready;
  logic [W-1:0] u0_data, u1_data, u3_data;
  logic         u0_valid, u1_valid, u3_valid;
  logic         u0_last, u1_last, u3_last;
  logic [1:0]   u0_grant, u1_grant, u3_grant;
  logic         u0_locked, u1_locked, u3_locked;
  logic [2:0]   u3_ready;

  stream_mux_n #(.N_CH(4), .W(W), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(u0_ready), .sel(sel),
    .out_data(u0_data), .out_valid(u0_valid), .out_last(u0_last),
    .out_ready(out_ready), .grant(u0_grant), .locked(u0_locked));

  stream_mux_n #(.N_CH(4), .W(W), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(u1_ready), .sel(sel),
    .out_data(u1_data), .out_valid(u1_valid), .out_last(u1_last),
    .out_ready(out_ready), .grant(u1_grant), .locked(u1_locked));

  stream_mux_n #(.N_CH(3), .W(W), .MODE(0)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data[3*W-1:0]),
    .in_valid(in_valid[2:0]), .in_last(in_last[2:0]),
    .in_ready(u3_ready), .sel(sel),
    .out_data(u3_data), .out_valid(u3_valid), .out_last(u3_last),
    .out_ready(out_ready), .grant(u3_grant), .locked(u3_locked));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit act = 1'b0;
  bit mon_en = 1'b0;
  logic [N-1:0] a_ready;
  logic [W-1:0] a_data;
  logic         a_valid, a_last, a_locked;
  logic [1:0]   a_grant;

  always_comb begin
    a_ready  = act ? u1_ready  : u0_ready;
    a_data   = act ? u1_data   : u0_data;
    a_valid  = act ? u1_valid  : u0_valid;
    a_last   = act ? u1_last   : u0_last;
    a_locked = act ? u1_locked : u0_locked;
    a_grant  = act ? u1_grant  : u0_grant;
  end

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];
  int pc[$];
  int gl[$];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  task automatic monitor();
    logic pl;
    logic [W:0] e;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (a_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            chk("beat", {a_last, a_data}, e);
            pc.push_back(cyc);
          end
        end
        if (a_locked && !pl)
          gl.push_back(int'(a_grant));
        if (a_ready != '0)
          chk("ready_onehot", $onehot(a_ready), 1);
      end
      pl = a_locked;
    end
  endtask

  task automatic expect_pkt(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), W'(int'(base) + i)});
  endtask

  task automatic send(input int ch, input logic [W-1:0] base,
                      input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      in_data[ch*W +: W] = W'(int'(base) + i);
      in_last[ch]  = (i == n - 1);
      in_valid[ch] = 1'b1;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!a_ready[ch] && t < 50);
      chk($sformatf("ready_wait_ch%0d", ch), (t < 50), 1);
      if (t >= 50) break;
      @(posedge clk);
      #1;
    end
    in_valid[ch] = 1'b0;
    in_last[ch]  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    in_valid = '0;
    in_last = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    pc.delete();
    gl.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    fork
      monitor();
    join_none

    // reset held with all channels valid
    act = 1'b1;
    in_valid = '1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", u1_valid, 0);
      chk("rst_in_ready", u1_ready, 0);
      chk("rst_locked", u1_locked, 0);
    end
    chk("rst_out_data", u1_data, 0);
    chk("rst_grant", u1_grant, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rr_first_grant", u1_grant, 0);
    chk("rr_first_locked", u1_locked, 1);

    // ext select, 3-beat packet, sel changed mid-packet
    act = 1'b0;
    do_reset();
    out_ready = 1'b1;
    sel = 2'd2;
    expect_pkt(8'hA1, 3);
    fork
      send(2, 8'hA1, 3);
      begin
        repeat (3) @(posedge clk);
        #1 sel = 2'd1;
      end
    join
    @(negedge clk);
    chk("t2_unlocked", u0_locked, 0);
    chk("t2_grant_held", u0_grant, 2);
    drain();
    chk("t2_pops", pc.size(), 3);
    if (pc.size() == 3) begin
      chk("t2_gap0", pc[1] - pc[0], 1);
      chk("t2_gap1", pc[2] - pc[1], 1);
    end

    // backpressure for 4 cycles mid-packet
    do_reset();
    out_ready = 1'b1;
    sel = 2'd0;
    expect_pkt(8'hB0, 6);
    fork
      send(0, 8'hB0, 6);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_data", u0_data, 8'hB2);
          chk("stall_valid", u0_valid, 1);
          chk("stall_in_ready", u0_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_pops", pc.size(), 6);

    // round-robin with 1-beat packets on every channel
    act = 1'b1;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      expect_pkt(W'(8'hC0 + i), 1);
    fork
      begin
        send(0, 8'hC0, 1);
        send(0, 8'hC4, 1);
      end
      send(1, 8'hC1, 1);
      send(2, 8'hC2, 1);
      send(3, 8'hC3, 1);
    join
    drain();
    chk("rr_grants", gl.size(), 5);
    if (gl.size() == 5) begin
      chk("rr_g0", gl[0], 0);
      chk("rr_g1", gl[1], 1);
      chk("rr_g2", gl[2], 2);
      chk("rr_g3", gl[3], 3);
      chk("rr_g4", gl[4], 0);
    end
    if (pc.size() == 5)
      for (int i = 1; i < 5; i++)
        chk($sformatf("rr_bubble%0d", i), pc[i] - pc[i-1], 2);

    // select of an idle or nonexistent channel never locks
    act = 1'b0;
    do_reset();
    out_ready = 1'b1;
    sel = 2'd3;
    in_valid = 4'b0111;
    repeat (5) begin
      @(negedge clk);
      chk("t5_locked", u0_locked, 0);
      chk("t5_in_ready", u0_ready, 0);
      chk("n3_locked", u3_locked, 0);
      chk("n3_in_ready", u3_ready, 0);
    end
    mon_en = 1'b0;
    sel = 2'd2;
    @(posedge clk);
    @(negedge clk);
    chk("n3_sel2_locked", u3_locked, 1);
    chk("n3_sel2_grant", u3_grant, 2);

    // reset pulse while locked with a stalled beat
    do_reset();
    out_ready = 1'b0;
    sel = 2'd1;
    in_data[1*W +: W] = 8'hD0;
    in_valid[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_pre_valid", u0_valid, 1);
    chk("t6_pre_locked", u0_locked, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = '0;
    @(negedge clk);
    chk("t6_out_valid", u0_valid, 0);
    chk("t6_locked", u0_locked, 0);
    chk("t6_out_data", u0_data, 0);
    out_ready = 1'b1;
    expect_pkt(8'hE0, 3);
    send(1, 8'hE0, 3);
    drain();
    chk("t6_pops", pc.size(), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
